// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//   Shared types and constants for the instruction fetch unit.
//   fetch_state_t : fetch sequencer states (IDLE, RD_LO, RD_HI, DONE)
//   ADDR_W_DEF    : default PC / memory address width
//   IR_LH_LOW/HIGH: values of the IR half-select strobe
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int ADDR_W_DEF = 16;

    localparam logic IR_LH_LOW  = 1'b0;
    localparam logic IR_LH_HIGH = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_LO = 2'd1,
        RD_HI = 2'd2,
        DONE  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_if
//   Memory read port plus instruction-register byte-load strobes.
//   master : the fetch unit (drives mem_rd, mem_addr, ir_write, ir_lh, ir_byte)
//   slave  : memory / IR side (drives mem_rdata, mem_ready)
//
//   Handshake: mem_rd is a request held high with mem_addr stable until a
//   cycle in which mem_ready=1; that cycle transfers mem_rdata. mem_ready
//   seen while mem_rd=0 carries no data and is ignored.
// -----------------------------------------------------------------------------
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 16
);
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic              mem_ready;
    logic              ir_write;
    logic              ir_lh;
    logic [7:0]        ir_byte;

    modport master (
        output mem_rd, mem_addr, ir_write, ir_lh, ir_byte,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_rd, mem_addr, ir_write, ir_lh, ir_byte,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/instr_fetch_unit_program_counter.sv
// -----------------------------------------------------------------------------
// program_counter
//   Holds the PC. load has priority over inc; increment wraps modulo 2^ADDR_W.
//   clk, rst  : clock, synchronous active-high reset (PC <= RESET_PC)
//   load      : load PC from load_val
//   load_val  : value to load
//   inc       : advance PC by one
//   pc        : current PC
// -----------------------------------------------------------------------------
module program_counter #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);
    logic [ADDR_W-1:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_val;
        end else if (inc) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;
endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   Fetches one 16-bit instruction as two byte reads (low at PC, high at PC+1)
//   and strobes each byte straight into the instruction register.
//   clk, rst   : clock, synchronous active-high reset
//   bus        : memory port + IR strobes (instr_fetch_unit_if.master)
//   start      : request a fetch (IDLE only)
//   pc_load    : load PC from pc_in (IDLE only; combined with start the
//                fetch begins at pc_in)
//   pc_out     : current PC
//   busy       : state != IDLE
//   fetch_done : one-cycle pulse, instruction fully loaded
//   fetch_err  : one-cycle pulse after a timeout abort
//   dbg_state  : current FSM state
//
//   Optional feature, macro FETCH_TIMEOUT_EN: a per-byte wait counter aborts
//   the fetch after TIMEOUT_CYCLES cycles without mem_ready, restoring the PC
//   to the fetch start address. Without the macro the unit waits forever and
//   fetch_err is tied 0.
// -----------------------------------------------------------------------------
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int RESET_PC       = 0,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic               clk,
    input  logic               rst,
    instr_fetch_unit_if.master bus,
    input  logic               start,
    input  logic               pc_load,
    input  logic [ADDR_W-1:0]  pc_in,
    output logic [ADDR_W-1:0]  pc_out,
    output logic               busy,
    output logic               fetch_done,
    output logic               fetch_err,
    output fetch_state_t       dbg_state
);
    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc;
    logic              in_read;
    logic              byte_ok;
    logic              pc_load_en;
    logic              timeout_hit;
    logic              pc_ld;
    logic [ADDR_W-1:0] pc_ld_val;

    assign in_read    = (state_q == RD_LO) || (state_q == RD_HI);
    // A byte transfers only while a read is outstanding.
    assign byte_ok    = in_read && bus.mem_ready;
    assign pc_load_en = (state_q == IDLE) && pc_load;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [ADDR_W-1:0] pc_base_q, pc_base_d;
    logic              err_q, err_d;

    // wait_cnt counts wait cycles already spent on the current byte, so the
    // abort fires during the TIMEOUT_CYCLES-th consecutive wait cycle.
    assign timeout_hit = in_read && !bus.mem_ready
                         && (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        pc_base_d  = pc_base_q;
        err_d      = timeout_hit;
        if (state_d != state_q) begin
            wait_cnt_d = '0;
        end else if (in_read && !bus.mem_ready) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
        if ((state_q == IDLE) && start) begin
            pc_base_d = pc_load ? pc_in : pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= '0;
            pc_base_q  <= ADDR_W'(RESET_PC);
            err_q      <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            pc_base_q  <= pc_base_d;
            err_q      <= err_d;
        end
    end

    assign fetch_err = err_q;
    assign pc_ld     = pc_load_en || timeout_hit;
    assign pc_ld_val = timeout_hit ? pc_base_q : pc_in;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout_hit        = 1'b0;
    assign fetch_err          = 1'b0;
    assign pc_ld              = pc_load_en;
    assign pc_ld_val          = pc_in;
`endif

    program_counter #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (ADDR_W'(RESET_PC))
    ) u_pc (
        .clk      (clk),
        .rst      (rst),
        .load     (pc_ld),
        .load_val (pc_ld_val),
        .inc      (byte_ok),
        .pc       (pc)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start) state_d = RD_LO;
            RD_LO: if (bus.mem_ready) state_d = RD_HI;
                   else if (timeout_hit) state_d = IDLE;
            RD_HI: if (bus.mem_ready) state_d = DONE;
                   else if (timeout_hit) state_d = IDLE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs; IR strobes are gated so nothing but pc_out is nonzero when idle.
    always_comb begin
        bus.mem_rd   = in_read;
        bus.mem_addr = in_read ? pc : '0;
        bus.ir_write = byte_ok;
        bus.ir_lh    = (byte_ok && (state_q == RD_HI)) ? IR_LH_HIGH : IR_LH_LOW;
        bus.ir_byte  = byte_ok ? bus.mem_rdata : 8'h00;
        busy         = (state_q != IDLE);
        fetch_done   = (state_q == DONE);
    end

    assign pc_out    = pc;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    localparam int W = 34;  // {kind[1:0], addr[15:0], data[15:0]}
    localparam logic [1:0] K_WR   = 2'd1;
    localparam logic [1:0] K_DONE = 2'd2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         start = 1'b0;
    logic         pc_load = 1'b0;
    logic [15:0]  pc_in = 16'h0;
    logic [15:0]  pc_out;
    logic         busy, fetch_done, fetch_err;
    fetch_state_t dbg_state;

    instr_fetch_unit_if #(.ADDR_W(16)) bus ();

    instr_fetch_unit #(
        .ADDR_W(16), .RESET_PC(0), .TIMEOUT_CYCLES(15)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.master),
        .start      (start),
        .pc_load    (pc_load),
        .pc_in      (pc_in),
        .pc_out     (pc_out),
        .busy       (busy),
        .fetch_done (fetch_done),
        .fetch_err  (fetch_err),
        .dbg_state  (dbg_state)
    );

    // ---------------- memory model ----------------
    logic [7:0] mem [0:65535];
    logic       ready_rand = 1'b0;
    logic       ready_force = 1'b0;
    logic       rnd_ready = 1'b1;
    assign bus.mem_rdata = mem[bus.mem_addr];
    assign bus.mem_ready = ready_rand ? rnd_ready : ready_force;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rnd_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int           errors = 0;
    int           checks = 0;
    logic [15:0]  ir_model = 16'h0;
    logic [15:0]  tb_pc = 16'h0;
    bit           err_allowed = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] ent(input logic [1:0] k, input logic [15:0] a,
                                         input logic [15:0] d);
        return {k, a, d};
    endfunction

    // Monitor: pops one expectation per IR write or fetch_done.
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (bus.ir_write === 1'b1) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                check("ir_write", ent(K_WR, bus.mem_addr, {7'b0, bus.ir_lh, bus.ir_byte}), e);
                if (bus.ir_lh) ir_model[15:8] = bus.ir_byte;
                else           ir_model[7:0]  = bus.ir_byte;
            end
            if (fetch_done === 1'b1) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                check("fetch_done", ent(K_DONE, pc_out, ir_model), e);
            end
            if (fetch_err === 1'b1 && !err_allowed)
                check("unexpected_fetch_err", 1, 0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("wait_idle_timeout", 1, 0);
    endtask

    // Issues one fetch at the start of a cycle (cycle 0) and returns at the
    // start of cycle 1 with start/pc_load released. partial=1 expects only
    // the low-byte write.
    task automatic fetch_issue(input bit do_load, input logic [15:0] target, input bit partial);
        logic [15:0] p, p1, p2;
        wait_idle();
        step();
        start   = 1'b1;
        pc_load = do_load;
        pc_in   = do_load ? target : 16'($urandom);
        if (do_load) tb_pc = target;
        p  = tb_pc;
        p1 = p + 16'd1;
        p2 = p + 16'd2;
        exp_q.push_back(ent(K_WR, p, {8'h00, mem[p]}));
        if (!partial) begin
            exp_q.push_back(ent(K_WR, p1, {8'h01, mem[p1]}));
            exp_q.push_back(ent(K_DONE, p2, {mem[p1], mem[p]}));
            tb_pc = p2;
        end
        step();
        start   = 1'b0;
        pc_load = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || busy !== 1'b0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("drain_timeout", 1, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h34;
        mem[1] = 8'h12;

        // Reset state
        rst = 1'b1;
        repeat (3) step();
        @(negedge clk);
        check("reset_outputs",
              {dbg_state, pc_out, busy, fetch_done, fetch_err, bus.mem_rd, bus.ir_write,
               bus.ir_lh, bus.ir_byte},
              {IDLE, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
        step();
        rst = 1'b0;
        tb_pc = 16'h0;

        // T1: minimum latency, IR = 0x1234
        ready_force = 1'b1;
        fetch_issue(0, 16'h0, 0);
        @(negedge clk);
        check("t1_c1_lo", {bus.ir_write, bus.ir_lh}, 2'b10);
        step();
        @(negedge clk);
        check("t1_c2_hi", {bus.ir_write, bus.ir_lh}, 2'b11);
        step();
        @(negedge clk);
        check("t1_c3_done", {fetch_done, pc_out}, {1'b1, 16'h0002});
        wait_drain();

        // T2: three wait cycles in RD_LO, done at cycle 6
        ready_force = 1'b0;
        fetch_issue(0, 16'h0, 0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check("t2_wait", {bus.mem_rd, bus.mem_addr, bus.ir_write}, {1'b1, 16'h0002, 1'b0});
            if (i < 3) step();
        end
        step();
        ready_force = 1'b1;
        step();
        @(negedge clk);
        check("t2_c5_no_done", fetch_done, 1'b0);
        step();
        @(negedge clk);
        check("t2_c6_done", fetch_done, 1'b1);
        wait_drain();

        // T3: load 0xFFFF with start, PC wraps
        fetch_issue(1, 16'hFFFF, 0);
        wait_drain();
        check("t3_pc_wrap", pc_out, 16'h0001);

        // T4: start/pc_load during RD_HI are ignored
        fetch_issue(0, 16'h0, 0);
        step();
        ready_force = 1'b0;
        start   = 1'b1;
        pc_load = 1'b1;
        pc_in   = 16'hABCD;
        @(negedge clk);
        check("t4_in_rd_hi", dbg_state, RD_HI);
        step();
        start   = 1'b0;
        pc_load = 1'b0;
        ready_force = 1'b1;
        wait_drain();
        repeat (5) @(negedge clk);
        check("t4_pc", pc_out, 16'h0003);
        tb_pc = 16'h0003;

        // T5: reset during RD_HI
        fetch_issue(0, 16'h0, 1);
        step();
        ready_force = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("t5_in_rd_hi", dbg_state, RD_HI);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("t5_after_rst", {dbg_state, pc_out, bus.ir_write, fetch_done},
              {IDLE, 16'h0000, 1'b0, 1'b0});
        check("t5_queue_empty", exp_q.size(), 0);
        tb_pc = 16'h0;

`ifdef FETCH_TIMEOUT_EN
        // T6: timeout on the high byte
        begin
            int n;
            ready_force = 1'b1;
            err_allowed = 1'b1;
            fetch_issue(1, 16'h0040, 1);
            step();
            ready_force = 1'b0;
            n = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (fetch_err === 1'b1) break;
                if (dbg_state == RD_HI) n++;
                step();
            end
            check("t6_wait_cycles", n, 15);
            check("t6_err_state", {fetch_err, pc_out, busy}, {1'b1, 16'h0040, 1'b0});
            step();
            err_allowed = 1'b0;
            ready_force = 1'b1;
            tb_pc = 16'h0040;
        end
`endif

        // Randomized fetches with random memory wait states
        ready_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            fetch_issue($urandom_range(0, 2) == 0, 16'($urandom), 0);
        end
        wait_drain();
        ready_rand = 1'b0;
        check("final_pc", pc_out, tb_pc);
        check("final_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
